tag_tree_arbiter: RTL

- Parametrised N-leaf tag arbitration tree that generalises the two-input tag tree node.
- Each leaf raises `rdy` to request service. The tree presents exactly one pending leaf's tag (leaf index + 1; 0 = none) to a single consumer.
- On consumer `ack`, the tree routes a one-hot ack back to the leaf it granted.
- Pipeline registers are inserted every `REG_EVERY` levels. Each node uses either fixed left-priority or round-robin fairness.
- It sits between the parallel BPF cores and the shared packet-buffer/forwarder arbitration.

---
 rtl/tag_tree_arbiter_pkg.sv | 21 ++
 rtl/tag_tree_arbiter_if.sv | 16 +
 rtl/tag_tree_arbiter_node.sv | 82 ++++++++
 rtl/tag_tree_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/tag_tree_arbiter_pkg.sv
// Shared definitions for the tag arbitration tree.
// Provides the "no tag" value, a constant-foldable ceil(log2) and the
// rule deciding which tree levels carry a pipeline register.
package tag_tree_arbiter_pkg;

    // Tag value presented when nothing is pending.
    localparam int TAG_NONE = 0;

    // Smallest r with 2**r >= n. Used at elaboration time only.
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Level 0 is the leaf-adjacent level; k == 0 keeps every level combinational.
    function automatic bit reg_at(input int level, input int k);
        return (k > 0) && (((level + 1) % k) == 0);
    endfunction

endpackage

// File: rtl/tag_tree_arbiter_if.sv
// Leaf-request / consumer-handshake bundle of the tag arbitration tree.
// master: the arbiter (drives leaf_ack, tag, rdy); slave: leaves + consumer.
// leaf_rdy is level-held until acked; a transfer happens on rdy && ack.
interface tag_tree_arbiter_if #(
    parameter int N_LEAVES = 4,
    parameter int TAG_SZ   = 5
);
    logic [N_LEAVES-1:0] leaf_rdy;
    logic [N_LEAVES-1:0] leaf_ack;
    logic [TAG_SZ-1:0]   tag;
    logic                rdy;
    logic                ack;

    modport master (input leaf_rdy, input ack, output leaf_ack, output tag, output rdy);
    modport slave  (output leaf_rdy, output ack, input leaf_ack, input tag, input rdy);
endinterface

// File: rtl/tag_tree_arbiter_node.sv
// Two-input tag tree node: picks one ready child and forwards its tag upward.
// Latency: 0 cycles when combinational, 1 cycle when REGISTERED (one-entry buffer).
// Backpressure: ack flows down to the selected child only; a registered node
// refills in the same cycle its entry is taken (no bubble).
// Ports: clk/rst (sync active-low), l_*/r_* child side, p_* parent side.
module tag_tree_node
    import tag_tree_arbiter_pkg::*;
#(
    parameter int TAG_SZ     = 5,
    parameter bit REGISTERED = 1'b0,
    parameter bit RR         = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l_rdy,
    input  logic [TAG_SZ-1:0] l_tag,
    input  logic              r_rdy,
    input  logic [TAG_SZ-1:0] r_tag,
    output logic              l_ack,
    output logic              r_ack,
    output logic              p_rdy,
    output logic [TAG_SZ-1:0] p_tag,
    input  logic              p_ack
);
    logic              ptr_q, ptr_d;    // 1 = prefer right on the next tie
    logic              sel_r;
    logic              take;            // a child token is consumed this cycle
    logic [TAG_SZ-1:0] sel_tag;

    always_comb begin
        sel_r   = r_rdy && (!l_rdy || (RR && ptr_q));
        sel_tag = sel_r ? r_tag : (l_rdy ? l_tag : TAG_SZ'(TAG_NONE));
        l_ack   = take && !sel_r;
        r_ack   = take && sel_r;
        // After a grant, the next tie goes to the side that was not granted.
        ptr_d   = take ? !sel_r : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= 1'b0;
        else      ptr_q <= ptr_d;
    end

    if (REGISTERED) begin : g_reg
        logic              valid_q, valid_d;
        logic [TAG_SZ-1:0] tag_q, tag_d;

        // Loads are held off during reset so no leaf is acked into a buffer
        // that is about to be cleared.
        assign take = rst && (!valid_q || p_ack) && (l_rdy || r_rdy);

        always_comb begin
            valid_d = valid_q;
            tag_d   = tag_q;
            if (take) begin
                valid_d = 1'b1;
                tag_d   = sel_tag;
            end else if (p_ack) begin
                valid_d = 1'b0;
                tag_d   = TAG_SZ'(TAG_NONE);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_q <= 1'b0;
                tag_q   <= TAG_SZ'(TAG_NONE);
            end else begin
                valid_q <= valid_d;
                tag_q   <= tag_d;
            end
        end

        assign p_rdy = valid_q;
        assign p_tag = tag_q;
    end else begin : g_comb
        assign take  = p_ack && (l_rdy || r_rdy);
        assign p_rdy = l_rdy || r_rdy;
        assign p_tag = sel_tag;
    end

endmodule

// File: rtl/tag_tree_arbiter.sv
// N-leaf tag arbitration tree: presents one pending leaf tag (index+1) to a consumer.
// Latency: leaf_rdy to rdy equals the number of registered levels (0 = combinational).
// Backpressure: consumer ack ripples down to exactly the granted path; one transfer/cycle.
// Ports: clk, rst (sync active-low), bus (leaf_rdy/leaf_ack, tag/rdy/ack).
module tag_tree_arbiter
    import tag_tree_arbiter_pkg::*;
#(
    parameter int N_LEAVES  = 4,
    parameter int TAG_SZ    = 5,
    parameter int REG_EVERY = 0,
    parameter bit RR        = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    tag_tree_arbiter_if.master  bus
);
    localparam int D = clog2(N_LEAVES);
    localparam int P = 1 << D;

    if (N_LEAVES < 2 || TAG_SZ < clog2(N_LEAVES + 1)) begin : g_param_err
        $error("tag_tree_arbiter: N_LEAVES must be >= 2 and TAG_SZ must hold N_LEAVES");
    end

    // g_lvl[0] holds the (padded) leaves, g_lvl[D] the root output.
    // Each level's ack vector is produced by the node row above it.
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int W = P >> l;
        logic [W-1:0]             rdy;
        logic [W-1:0]             ack;
        logic [W-1:0][TAG_SZ-1:0] tag;

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < W; i++) begin : g_pin
                if (i < N_LEAVES) begin : g_real
                    assign rdy[i] = bus.leaf_rdy[i];
                    assign tag[i] = TAG_SZ'(i + 1);
                end else begin : g_pad
                    // Padding never requests, so its ack can never rise.
                    logic pad_ack_unused;
                    assign rdy[i]         = 1'b0;
                    assign tag[i]         = TAG_SZ'(TAG_NONE);
                    assign pad_ack_unused = ack[i];
                end
            end
        end else begin : g_node
            logic [2*W-1:0] child_ack;
            for (genvar j = 0; j < W; j++) begin : g_n
                tag_tree_node #(
                    .TAG_SZ     (TAG_SZ),
                    .REGISTERED (reg_at(l - 1, REG_EVERY)),
                    .RR         (RR)
                ) u_node (
                    .clk   (clk),
                    .rst   (rst),
                    .l_rdy (g_lvl[l-1].rdy[2*j]),
                    .l_tag (g_lvl[l-1].tag[2*j]),
                    .r_rdy (g_lvl[l-1].rdy[2*j+1]),
                    .r_tag (g_lvl[l-1].tag[2*j+1]),
                    .l_ack (child_ack[2*j]),
                    .r_ack (child_ack[2*j+1]),
                    .p_rdy (rdy[j]),
                    .p_tag (tag[j]),
                    .p_ack (ack[j])
                );
            end
        end

        if (l == D) begin : g_root_ack
            assign ack[0] = rst && bus.ack;
        end else begin : g_down_ack
            assign ack = g_lvl[l+1].g_node.child_ack;
        end
    end

    assign bus.rdy      = rst && g_lvl[D].rdy[0];
    assign bus.tag      = rst ? g_lvl[D].tag[0] : TAG_SZ'(TAG_NONE);
    assign bus.leaf_ack = rst ? g_lvl[0].ack[N_LEAVES-1:0] : '0;

endmodule
